// File: rtl/rd_arbiter_if.sv
// Bundle of request/grant signals between the requesters and rd_arbiter.
//   req     : per-requester read request (level)
//   ds      : data strobe / transfer complete from the shared read controller
//   gnt     : one-hot grant (registered)
//   go      : start pulse to the shared read controller (registered)
//   done    : one-cycle completion pulse on the granted requester's bit
//   timeout : one-cycle abort pulse
//   busy    : arbiter is not idle
interface rd_arbiter_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0] req;
  logic            ds;
  logic [NREQ-1:0] gnt;
  logic            go;
  logic [NREQ-1:0] done;
  logic            timeout;
  logic            busy;

  modport master (
    output req, ds,
    input  gnt, go, done, timeout, busy
  );

  modport slave (
    input  req, ds,
    output gnt, go, done, timeout, busy
  );
endinterface

// File: rtl/rd_arbiter.sv
// Round-robin arbiter giving NREQ requesters turns on one shared read
// controller. Each transaction walks IDLE -> GRANT -> WAIT -> RELEASE.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-high
//   bus   : rd_arbiter_if slave side (req/ds in; gnt/go/done/timeout/busy out)
// WAIT ends on ds (done pulse) or after TIMEOUT cycles without ds (timeout
// pulse); ds wins if both happen in the same cycle.
module rd_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic         clock,
  input  logic         reset,
  rd_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t          state, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            go_q, go_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   win_q, win_d;
  logic [NREQ-1:0] done_c;
  logic            timeout_c;

  logic [IW-1:0]   pick;
  logic            found;

  // Search upward from last+1 with wrap; last itself is checked last.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      int unsigned j;
      j = (32'(last_q) + i) % 32'(NREQ);
      if (!found && bus.req[j]) begin
        found = 1'b1;
        pick  = IW'(j);
      end
    end
  end

  always_comb begin
    state_d   = state;
    gnt_d     = gnt_q;
    go_d      = 1'b0;
    cnt_d     = cnt_q;
    last_d    = last_q;
    win_d     = win_q;
    done_c    = '0;
    timeout_c = 1'b0;
    case (state)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          gnt_d   = NREQ'(1) << pick;
          win_d   = pick;
          go_d    = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.ds) begin
          done_c  = gnt_q;
          state_d = RELEASE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_c = 1'b1;
          state_d   = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        // gnt stays visible through RELEASE and clears on the edge into IDLE.
        last_d  = win_q;
        gnt_d   = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      gnt_q  <= '0;
      go_q   <= 1'b0;
      cnt_q  <= '0;
      last_q <= IW'(NREQ - 1);
      win_q  <= '0;
    end else begin
      state  <= state_d;
      gnt_q  <= gnt_d;
      go_q   <= go_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      win_q  <= win_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.go      = go_q;
  assign bus.done    = done_c;
  assign bus.timeout = timeout_c;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_rd_arbiter.sv
// Scoreboard bench for rd_arbiter (NREQ=4, TIMEOUT=15): stimulus pushes the
// expected grant/completion of each transaction; the monitor pops and
// compares whenever go, done or timeout appears.
module tb_rd_arbiter;
  localparam int NREQ = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_GRANT = 2'd1, S_WAIT = 2'd2, S_RELEASE = 2'd3;

  logic clock = 1'b0;
  logic reset;

  rd_arbiter_if #(.NREQ(NREQ)) bus();

  rd_arbiter #(.NREQ(NREQ), .TIMEOUT(15)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] g;
    logic [3:0] d;
    logic       to;
    int         w;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   wcnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor
  always @(negedge clock) begin
    if (!reset) begin
      check("gnt_onehot", 32'($onehot0(bus.gnt)), 32'd1);
      if (bus.go) begin
        check("go_with_gnt", 32'(bus.gnt != '0), 32'd1);
        if (sb.size() == 0) check("go_unexpected", 32'd1, 32'd0);
        else check("grant_value", 32'(bus.gnt), 32'(sb[0].g));
        wcnt = 0;
      end
      if (dut.state == S_WAIT) wcnt++;
      if (bus.done != '0 || bus.timeout) begin
        if (sb.size() == 0) begin
          check("spurious_pulse", 32'({bus.done, bus.timeout}), 32'd0);
        end else begin
          me = sb.pop_front();
          check("done_value", 32'(bus.done), 32'(me.d));
          check("timeout_value", 32'(bus.timeout), 32'(me.to));
          check("wait_cycle", 32'(wcnt), 32'(me.w));
          check("busy_in_wait", 32'(bus.busy), 32'd1);
        end
      end
    end
  end

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = '0;
    bus.ds  = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    sb.delete();
  endtask

  // One transaction; caller has already set req. ds_at = WAIT cycle on which
  // ds is pulsed (0 = never).
  task automatic txn(input logic [3:0] eg, input int ds_at, input bit drop_req,
                     input logic [3:0] ed, input logic eto, input int ew);
    exp_t e;
    int k;
    int w;
    e.g = eg; e.d = ed; e.to = eto; e.w = ew;
    sb.push_back(e);
    k = 0;
    do begin
      @(posedge clock); #1;
      k++;
    end while (dut.state != S_GRANT && k < 20);
    check("go_latency", 32'(k), 32'd1);
    check("grant_go", 32'(bus.go), 32'd1);
    if (drop_req) bus.req = '0;
    k = 0;
    w = 0;
    while (k < 40) begin
      @(posedge clock); #1;
      bus.ds = 1'b0;
      k++;
      if (dut.state == S_RELEASE) break;
      if (dut.state == S_WAIT) begin
        w++;
        if (w == ds_at) bus.ds = 1'b1;
      end
    end
    check("reached_release", 32'(dut.state), 32'(S_RELEASE));
    check("gnt_held_release", 32'(bus.gnt), 32'(eg));
    @(posedge clock); #1;
    check("idle_after_release", 32'(dut.state), 32'(S_IDLE));
    check("gnt_zero_idle", 32'(bus.gnt), 32'd0);
  endtask

  logic [3:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    // Reset with everything asserted
    reset   = 1'b1;
    bus.req = 4'b1111;
    bus.ds  = 1'b1;
    #1;
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    check("rst_outs", 32'({bus.gnt, bus.go, bus.done, bus.timeout, bus.busy}), 32'd0);
    repeat (3) begin
      @(posedge clock); #1;
      check("rst_hold_state", 32'(dut.state), 32'(S_IDLE));
      check("rst_hold_outs", 32'({bus.gnt, bus.go, bus.done, bus.timeout, bus.busy}), 32'd0);
    end
    bus.req = '0;
    bus.ds  = 1'b0;
    reset   = 1'b0;
    @(posedge clock); #1;
    check("idle_no_req", 32'(dut.state), 32'(S_IDLE));
    check("idle_no_req_gnt", 32'(bus.gnt), 32'd0);

    // Single request, ds on 3rd WAIT cycle, req dropped after grant
    bus.req = 4'b0100;
    txn(4'b0100, 3, 1'b1, 4'b0100, 1'b0, 3);

    // Round robin from reset
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 5; i++) txn(rr_exp[i], 1, 1'b0, rr_exp[i], 1'b0, 1);
    bus.req = '0;
    repeat (2) @(posedge clock);
    #1 check("rr_idle", 32'(dut.state), 32'(S_IDLE));

    // Timeout
    bus.req = 4'b0010;
    txn(4'b0010, 0, 1'b1, 4'b0000, 1'b1, 15);

    // ds coinciding with the timeout cycle
    bus.req = 4'b0010;
    txn(4'b0010, 15, 1'b1, 4'b0010, 1'b0, 15);

    // Mid-transaction reset after grant to req[3]
    do_reset();
    bus.req = 4'b1000;
    me.g = 4'b1000; me.d = 4'b0000; me.to = 1'b0; me.w = 0;
    sb.push_back(me);
    @(posedge clock); #1;
    check("mid_grant_state", 32'(dut.state), 32'(S_GRANT));
    bus.req = '0;
    repeat (2) @(posedge clock);
    #1 check("mid_in_wait", 32'(dut.state), 32'(S_WAIT));
    #2 reset = 1'b1;
    #1;
    check("mid_rst_state", 32'(dut.state), 32'(S_IDLE));
    check("mid_rst_outs", 32'({bus.gnt, bus.go, bus.done, bus.timeout, bus.busy}), 32'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    sb.delete();
    bus.req = 4'b1001;
    txn(4'b0001, 2, 1'b1, 4'b0001, 1'b0, 2);

    // Stray ds while idle
    bus.ds = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
      check("stray_ds_pulses", 32'({bus.done, bus.timeout}), 32'd0);
      check("stray_ds_state", 32'(dut.state), 32'(S_IDLE));
    end
    bus.ds = 1'b0;

    repeat (2) @(posedge clock);
    #1 check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
